// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI slave and the master side of the link:
//   TRAN_WIDTH_DEF  default word length in bits (legal range 8..32)
//   CNT_W           width of the per-word bit counter
//   spi_state_e     slave frame-tracking FSM encoding
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int TRAN_WIDTH_DEF = 24;
   localparam int CNT_W          = 6;

   typedef enum logic [1:0] {
      s_Idle   = 2'd0,  // SS high, tx word follows i_SPI_Send_Data
      s_Active = 2'd1,  // frame armed from s_Idle, shifting words
      s_Flush  = 2'd2   // SS low but not armed; wait for SS high
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the clk_i domain through two flops, then
// keeps a third flop so single-cycle rise/fall strobes can be derived.
//   clk_i   system clock
//   rst_i   synchronous active-high reset; all three flops load RST_VAL
//   d_i     asynchronous pin
//   sync_o  synchronized level
//   rise_o  one-cycle strobe on a synchronized 0->1 transition
//   fall_o  one-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         dly_q  <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave, SCLK idle low, MOSI sampled on SCLK falling edges, MISO advanced
// on SCLK rising edges, MSB first. Everything runs on c_clk_100m; the SPI pins
// are oversampled (SCLK up to c_clk_100m/8).
//   c_clk_100m           system clock
//   i_rst                synchronous active-high reset
//   i_SPI_Send_Data      word returned on MISO, frozen at the start of a word
//   o_SPI_Send_Load_ack  toggles whenever a send word is frozen
//   o_SPI_Receive_Sync   toggles once per completed received word
//   o_SPI_Receive_Data   last completed received word
//   o_Error_Count        frames aborted mid-word, saturating at 255
//   i_SPI_Clk/SS/MOSI    asynchronous SPI pins, SS active low
//   o_SPI_MISO           serial data out (MSB of the tx shift register)
//   o_SPI_MISO_oe        high while synchronized SS is low
//   o_Dbg_State          current FSM state for observation
//
// Handshake: there is no valid/ready flow control. Each toggle of
// o_SPI_Receive_Sync marks o_SPI_Receive_Data as a new word, stable until the
// next toggle; each toggle of o_SPI_Send_Load_ack marks that i_SPI_Send_Data
// was just captured and the next word may be presented.
// -----------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int TRAN_WIDTH = TRAN_WIDTH_DEF
) (
   input  logic                  c_clk_100m,
   input  logic                  i_rst,
   input  logic [TRAN_WIDTH-1:0] i_SPI_Send_Data,
   output logic                  o_SPI_Send_Load_ack,
   output logic                  o_SPI_Receive_Sync,
   output logic [TRAN_WIDTH-1:0] o_SPI_Receive_Data,
   output logic [7:0]            o_Error_Count,
   input  logic                  i_SPI_Clk,
   input  logic                  i_SPI_SS,
   input  logic                  i_SPI_MOSI,
   output logic                  o_SPI_MISO,
   output logic                  o_SPI_MISO_oe,
   output spi_state_e            o_Dbg_State
);

   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(TRAN_WIDTH);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise, ss_fall;
   logic mosi_sync, mosi_rise, mosi_fall;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk_i (c_clk_100m), .rst_i (i_rst), .d_i (i_SPI_Clk),
      .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
      .clk_i (c_clk_100m), .rst_i (i_rst), .d_i (i_SPI_SS),
      .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk_i (c_clk_100m), .rst_i (i_rst), .d_i (i_SPI_MOSI),
      .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   spi_state_e            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [TRAN_WIDTH-1:0] rx_q;
   logic [TRAN_WIDTH-1:0] tx_q;
   logic                  armed_q;   // a falling edge was seen in this word
   logic [1:0]            settle_q;  // synchronizers refilled from the pins
   logic [TRAN_WIDTH-1:0] rx_data_q;
   logic                  rx_sync_q;
   logic                  ack_q;
   logic [7:0]            err_q;

   logic [TRAN_WIDTH-1:0] rx_d;
   logic [CNT_W-1:0]      cnt_d;
   logic                  word_done;

   assign rx_d      = {rx_q[TRAN_WIDTH-2:0], mosi_sync};
   assign cnt_d     = cnt_q + 1'b1;
   assign word_done = (cnt_d == WIDTH_CNT);

   // Pin-level observations not needed by the frame logic.
   logic unused_sigs;
   assign unused_sigs = ^{sclk_sync, mosi_rise, mosi_fall, rx_q[TRAN_WIDTH-1]};

   always_ff @(posedge c_clk_100m) begin
      if (i_rst) begin
         state_q   <= s_Flush;
         cnt_q     <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         armed_q   <= 1'b0;
         settle_q  <= 2'd0;
         rx_data_q <= '0;
         rx_sync_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 8'd0;
      end else begin
         // The SS synchronizer resets to "high"; wait until it holds real pin
         // samples so a frame already in progress is not mistaken for idle.
         if (settle_q != 2'd3) begin
            settle_q <= settle_q + 2'd1;
         end

         case (state_q)
            s_Flush: begin
               if ((settle_q == 2'd3) && ss_sync) begin
                  state_q <= s_Idle;
               end
            end

            s_Idle: begin
               // Tracking load keeps the MSB on MISO before SS falls; the load
               // in the SS-fall cycle is the one that freezes the word.
               tx_q <= i_SPI_Send_Data;
               if (ss_fall) begin
                  state_q <= s_Active;
                  cnt_q   <= '0;
                  rx_q    <= '0;
                  armed_q <= 1'b0;
                  ack_q   <= ~ack_q;
               end
            end

            s_Active: begin
               // SS rising has priority over any coincident SCLK edge.
               if (ss_rise) begin
                  state_q <= s_Idle;
                  cnt_q   <= '0;
                  if ((cnt_q != '0) && (err_q != 8'hFF)) begin
                     err_q <= err_q + 8'd1;
                  end
               end else if (sclk_fall) begin
                  rx_q <= rx_d;
                  if (word_done) begin
                     rx_data_q <= rx_d;
                     rx_sync_q <= ~rx_sync_q;
                     cnt_q     <= '0;
                     tx_q      <= i_SPI_Send_Data;
                     ack_q     <= ~ack_q;
                     armed_q   <= 1'b0;
                  end else begin
                     cnt_q   <= cnt_d;
                     armed_q <= 1'b1;
                  end
               end else if (sclk_rise && armed_q) begin
                  // The rising edge that opens a word leaves the MSB in place.
                  tx_q <= {tx_q[TRAN_WIDTH-2:0], 1'b0};
               end
            end

            default: state_q <= s_Flush;
         endcase
      end
   end

   assign o_SPI_Send_Load_ack = ack_q;
   assign o_SPI_Receive_Sync  = rx_sync_q;
   assign o_SPI_Receive_Data  = rx_data_q;
   assign o_Error_Count       = err_q;
   assign o_SPI_MISO          = tx_q[TRAN_WIDTH-1];
   assign o_SPI_MISO_oe       = ~ss_sync;
   assign o_Dbg_State         = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Drives a 12.5 MHz SPI master into a 24-bit and an 8-bit spi_slave sharing the
// SPI pins. The master changes MOSI with each SCLK rise and reads MISO at the
// end of the high phase. Expected received words go into exp_q and are popped
// on every o_SPI_Receive_Sync toggle; error count and last word are predicted
// from the frame rules (full word -> new data, nonzero partial -> +1 error).
// -----------------------------------------------------------------------------
module tb_spi_slave;
   import spi_pkg::*;

   // ---------------- clock / reset / DUTs ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        sclk, ss_n, mosi;
   logic [23:0] send24;
   logic [7:0]  send8;

   logic        ack24, sync24, miso24, oe24;
   logic [23:0] rx24;
   logic [7:0]  err24;
   spi_state_e  dbg24;

   logic        ack8, sync8, miso8, oe8;
   logic [7:0]  rx8;
   logic [7:0]  err8;
   spi_state_e  dbg8;

   always #5 clk = ~clk;

   spi_slave #(.TRAN_WIDTH(24)) u_dut (
      .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Data(send24),
      .o_SPI_Send_Load_ack(ack24), .o_SPI_Receive_Sync(sync24),
      .o_SPI_Receive_Data(rx24), .o_Error_Count(err24),
      .i_SPI_Clk(sclk), .i_SPI_SS(ss_n), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso24), .o_SPI_MISO_oe(oe24), .o_Dbg_State(dbg24)
   );

   spi_slave #(.TRAN_WIDTH(8)) u_dut8 (
      .c_clk_100m(clk), .i_rst(rst), .i_SPI_Send_Data(send8),
      .o_SPI_Send_Load_ack(ack8), .o_SPI_Receive_Sync(sync8),
      .o_SPI_Receive_Data(rx8), .o_Error_Count(err8),
      .i_SPI_Clk(sclk), .i_SPI_SS(ss_n), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso8), .o_SPI_MISO_oe(oe8), .o_Dbg_State(dbg8)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_word;
   logic [23:0] last_rx;
   int          exp_err;
   logic        mon_en = 1'b0;
   logic        sel8   = 1'b0;
   logic        sync_prev = 1'b0;
   logic        ack_prev  = 1'b0;
   int          sync_cnt  = 0;
   int          ack_cnt   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every Receive_Sync toggle must deliver the oldest expected word.
   always @(negedge clk) begin
      if (mon_en && (sync24 !== sync_prev)) begin
         sync_cnt++;
         if (exp_q.size() == 0) begin
            check("sync_without_word", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_word = exp_q.pop_front();
            check("rx_word", {8'h0, rx24}, {8'h0, exp_word});
         end
      end
      if (mon_en && (ack24 !== ack_prev)) ack_cnt++;
      sync_prev = sync24;
      ack_prev  = ack24;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic bit_xfer(input logic b, output logic m);
      sclk = 1'b1;
      mosi = b;
      #38;
      m = sel8 ? miso8 : miso24;
      #2;
      sclk = 1'b0;
      #40;
   endtask

   task automatic send_word(input logic [31:0] w, input int n, output logic [31:0] cap);
      logic m;
      cap = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bit_xfer(w[i], m);
         cap = {cap[30:0], m};
      end
   endtask

   task automatic ss_fall();
      ss_n = 1'b0;
      #100;
   endtask

   task automatic ss_rise();
      ss_n = 1'b1;
      #100;
   endtask

   task automatic reset_pulse_checked();
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_rx_data", {8'h0, rx24}, 32'h0);
      check("rst_rx_sync", {31'h0, sync24}, 32'h0);
      check("rst_load_ack", {31'h0, ack24}, 32'h0);
      check("rst_err_cnt", {24'h0, err24}, 32'h0);
      check("rst_miso", {31'h0, miso24}, 32'h0);
      check("rst_miso_oe", {31'h0, oe24}, 32'h0);
      check("rst_state", {30'h0, dbg24}, {30'h0, s_Flush});
      exp_q.delete();
      last_rx = '0;
      exp_err = 0;
      repeat (10) @(negedge clk);
      mon_en = 1'b1;
   endtask

   // One SS frame carrying nbits of w; expectations supplied by the caller.
   task automatic run_frame(input logic [23:0] w, input logic [23:0] sd, input int nbits,
                            input logic [23:0] e_rx, input int e_err);
      logic [31:0] cap;
      int          ack0;
      ack0 = ack_cnt;
      if (nbits == 24) exp_q.push_back(w);
      send24 = sd;
      #20;
      ss_fall();
      check("miso_oe_active", {31'h0, oe24}, 32'h1);
      send_word({8'h0, w}, nbits, cap);
      ss_rise();
      if (nbits == 24) check("miso_word", cap, {8'h0, sd});
      check("rx_data", {8'h0, rx24}, {8'h0, e_rx});
      check("err_cnt", {24'h0, err24}, 32'(e_err));
      // SS fall freezes one word; a completed word re-arms for the next one.
      check("ack_toggles", 32'(ack_cnt - ack0), (nbits == 24) ? 32'd2 : 32'd1);
      check("miso_oe_idle", {31'h0, oe24}, 32'h0);
   endtask

   // Reference rules for one frame.
   task automatic model_frame(input logic [23:0] w, input int nbits);
      if (nbits == 24) last_rx = w;
      else if (nbits > 0) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [23:0] mosi_w;
      logic [23:0] send_w;
      int          nbits;
      logic [23:0] exp_rx;
      int          exp_err;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [31:0] cap1, cap2;
      logic [23:0] w, sd;
      int          nb, ack0, sync0, lat;
      logic        s0;

      rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      send24 = '0; send8 = '0;
      last_rx = '0; exp_err = 0;

      tbl[0] = '{24'hA5C33C, 24'h123456, 24, 24'hA5C33C, 0};
      tbl[1] = '{24'hFFFFFF, 24'h000000, 24, 24'hFFFFFF, 0};
      tbl[2] = '{24'h000000, 24'hFFFFFF, 24, 24'h000000, 0};
      tbl[3] = '{24'h0F0F0F, 24'h800001, 10, 24'h000000, 1};
      tbl[4] = '{24'h123456, 24'h654321,  0, 24'h000000, 1};
      tbl[5] = '{24'hC0FFEE, 24'h00FF00, 23, 24'h000000, 2};
      tbl[6] = '{24'h800001, 24'h7FFFFE, 24, 24'h800001, 2};
      tbl[7] = '{24'h3C5AA5, 24'hA55A3C,  1, 24'h800001, 3};

      reset_pulse_checked();

      for (int i = 0; i < 8; i++) begin
         run_frame(tbl[i].mosi_w, tbl[i].send_w, tbl[i].nbits, tbl[i].exp_rx, tbl[i].exp_err);
      end
      last_rx = tbl[7].exp_rx;
      exp_err = tbl[7].exp_err;

      // Two words in one frame; the second send word is presented after the
      // first is frozen and must come out as the second MISO word.
      ack0 = ack_cnt; sync0 = sync_cnt;
      exp_q.push_back(24'h000001);
      exp_q.push_back(24'hFFFFFE);
      send24 = 24'hABCDEF;
      #20;
      ss_fall();
      send24 = 24'h13579B;
      send_word(32'h000001, 24, cap1);
      send_word(32'hFFFFFE, 24, cap2);
      ss_rise();
      model_frame(24'h000001, 24);
      model_frame(24'hFFFFFE, 24);
      check("b2b_miso_w1", cap1, 32'hABCDEF);
      check("b2b_miso_w2", cap2, 32'h13579B);
      check("b2b_sync_toggles", 32'(sync_cnt - sync0), 32'd2);
      check("b2b_ack_toggles", 32'(ack_cnt - ack0), 32'd3);
      check("b2b_rx_data", {8'h0, rx24}, {8'h0, last_rx});

      // Randomized frames against the model.
      for (int i = 0; i < 16; i++) begin
         w  = 24'($urandom);
         sd = 24'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 23)) : 24;
         model_frame(w, nb);
         run_frame(w, sd, nb, last_rx, exp_err);
      end

      // Receive latency from the last SCLK falling edge on the pin.
      w = 24'($urandom);
      exp_q.push_back(w);
      send24 = 24'($urandom);
      #20;
      ss_fall();
      send_word({9'h0, w[23:1]}, 23, cap1);
      s0 = sync24;
      sclk = 1'b1; mosi = w[0];
      #40;
      sclk = 1'b0;
      lat = -1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         if ((lat < 0) && (sync24 !== s0)) lat = c;
      end
      check("sync_latency_le4", 32'((lat >= 1) && (lat <= 4)), 32'd1);
      @(negedge clk);
      #30;
      ss_rise();
      model_frame(w, 24);
      check("lat_rx_data", {8'h0, rx24}, {8'h0, last_rx});

      // Reset in the middle of a frame: rest of the frame is ignored.
      send24 = 24'h0F1E2D;
      #20;
      ss_fall();
      send_word(32'hFFF, 12, cap1);
      reset_pulse_checked();
      send_word(32'h000, 12, cap1);
      check("flush_hold_state", {30'h0, dbg24}, {30'h0, s_Flush});
      s0 = sync24;
      ss_rise();
      check("flush_no_sync", {31'h0, sync24}, {31'h0, s0});
      check("flush_err_cnt", {24'h0, err24}, 32'h0);
      check("flush_rx_data", {8'h0, rx24}, 32'h0);
      model_frame(24'h5A5A5A, 24);
      run_frame(24'h5A5A5A, 24'h2468AC, 24, last_rx, exp_err);

      // 8-bit instance: send data changes after SS fall.
      sel8 = 1'b1;
      s0 = sync8;
      send8 = 8'hC3;
      #20;
      ss_fall();
      send8 = 8'h3C;
      send_word(32'h81, 8, cap1);
      ss_rise();
      sel8 = 1'b0;
      model_frame(24'h0, 8);   // same pins seen by the 24-bit DUT: an abort
      check("w8_rx_data", {24'h0, rx8}, 32'h81);
      check("w8_sync_toggled", {31'h0, sync8}, {31'h0, ~s0});
      check("w8_miso_word", cap1, 32'hC3);
      check("w8_err24", {24'h0, err24}, 32'(exp_err));

      // 300 one-bit aborts: error count saturates.
      ack0 = ack_cnt;
      for (int i = 0; i < 300; i++) begin
         ss_n = 1'b0; #60;
         sclk = 1'b1; #40;
         sclk = 1'b0; #40;
         ss_n = 1'b1; #60;
         model_frame(24'h0, 1);
      end
      #40;
      check("sat_err_cnt", {24'h0, err24}, 32'(exp_err));
      check("sat_ack_toggles", 32'(ack_cnt - ack0), 32'd300);
      check("sat_rx_data", {8'h0, rx24}, {8'h0, last_rx});

      repeat (20) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
